// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between the icache and dcache: round-robin grant,
// four-beat line reads/writebacks, and a one-cycle response to the owning cache.
module cache_mem_arbiter #(
    parameter  int unsigned LINE_W = 256,
    parameter  int unsigned BEAT_W = 64,
    parameter  int unsigned BEATS  = 4,
    localparam int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFS_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFS_W) - 1);
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               pmem_read_q, pmem_read_d;
    logic               pmem_write_q, pmem_write_d;
    logic               i_resp_q, i_resp_d;
    logic               d_resp_q, d_resp_d;
    logic [LINE_W-1:0]  i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]  d_rdata_q, d_rdata_d;
    logic [BEAT_W-1:0]  wdata_c;

    logic d_req_c;
    logic any_req_c;
    logic grant_d_c;
    logic beat_last_c;

    assign d_req_c     = d_read | d_write;
    assign any_req_c   = d_req_c | i_read;
    // On a tie the dcache wins only if the icache was granted last time.
    assign grant_d_c   = d_req_c & (~i_read | (last_grant_q == GRANT_I));
    assign beat_last_c = (beat_q == LAST_BEAT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a simultaneous dcache read+write resolves to the write
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    state_d = (grant_d_c && d_write) ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (pmem_resp && beat_last_c) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        pmem_read_d  = (state_d == RD_BURST);
        pmem_write_d = (state_d == WR_BURST);
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        wdata_c      = '0;

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    owner_d = grant_d_c ? GRANT_D : GRANT_I;
                    addr_d  = (grant_d_c ? d_addr : i_addr) & LINE_MASK;
                    beat_d  = '0;
                end
            end
            RD_BURST: begin
                if (pmem_resp) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_q == CNT_W'(b)) begin
                            if (owner_q == GRANT_D) begin
                                d_rdata_d[b*BEAT_W +: BEAT_W] = pmem_rdata;
                            end else begin
                                i_rdata_d[b*BEAT_W +: BEAT_W] = pmem_rdata;
                            end
                        end
                    end
                    if (!beat_last_c) begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            WR_BURST: begin
                for (int b = 0; b < BEATS; b++) begin
                    if (beat_q == CNT_W'(b)) begin
                        wdata_c = d_wdata[b*BEAT_W +: BEAT_W];
                    end
                end
                if (pmem_resp && !beat_last_c) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            RESP: begin
                last_grant_d = owner_q;
            end
            default: ;
        endcase

        if (state_d == RESP) begin
            i_resp_d = (owner_d == GRANT_I);
            d_resp_d = (owner_d == GRANT_D);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            beat_q       <= '0;
            addr_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_rdata      = i_rdata_q;
    assign i_resp       = i_resp_q;
    assign d_rdata      = d_rdata_q;
    assign d_resp       = d_resp_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_c;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a small burst-memory responder with a
// programmable pmem_resp pattern, plus one task per scenario.
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    logic         pmem_resp  = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [63:0] rd_beats [4];
    bit          pat [8];
    int          pat_len  = 1;
    int          pat_idx  = 0;
    int          beat_idx = 0;
    logic [63:0] wq [$];

    cache_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: decides each beat on the falling edge, accepted on the next rising edge.
    always @(negedge clk) begin
        if (rst && (pmem_read || pmem_write)) begin
            if (pat[pat_idx % pat_len]) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd_beats[beat_idx % 4];
                if (pmem_write) wq.push_back(pmem_wdata);
                beat_idx++;
            end else begin
                pmem_resp  = 1'b0;
                pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
            pat_idx++;
        end else begin
            pmem_resp  = 1'b0;
            pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            pat_idx    = 0;
            beat_idx   = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!(d_read && d_write)) else $error("FAIL illegal_dreq d_read and d_write both high");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        rst     = 1'b0;
        wait_cycle();
        wait_cycle();
        rst = 1'b1;
        wait_cycle();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        i_addr  = 32'h0;
        d_addr  = 32'h0;
        d_wdata = {4{64'hFFFF_0000_FFFF_0000}};
        pat_len = 1;
        pat[0]  = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL reset_pmem_read got=%0b exp=0", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_write got=%0b exp=0", pmem_write); end
        checks++; if (pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_address got=%h exp=0", pmem_address); end
        checks++; if (pmem_wdata !== 64'h0) begin failures++; $display("FAIL reset_pmem_wdata got=%h exp=0", pmem_wdata); end
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL reset_resp got=%0b%0b exp=00", i_resp, d_resp); end
        checks++; if (i_rdata !== 256'h0) begin failures++; $display("FAIL reset_i_rdata got=%h exp=0", i_rdata); end
        checks++; if (d_rdata !== 256'h0) begin failures++; $display("FAIL reset_d_rdata got=%h exp=0", d_rdata); end
        wait_cycle();
        rst = 1'b1;
        wait_cycle();
        checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin failures++; $display("FAIL reset_idle_ctrl got=%0b%0b exp=00", pmem_read, pmem_write); end
    endtask

    task automatic test_icache_read();
        int lat;
        bit got;
        rd_beats[0] = 64'h1111_1111_1111_1111;
        rd_beats[1] = 64'h2222_2222_2222_2222;
        rd_beats[2] = 64'h3333_3333_3333_3333;
        rd_beats[3] = 64'h4444_4444_4444_4444;
        i_addr = 32'h6000_0064;
        i_read = 1'b1;
        wait_cycle();
        lat = 1;
        checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL iread_start got=%0b exp=1", pmem_read); end
        checks++; if (pmem_write !== 1'b0) begin failures++; $display("FAIL iread_no_write got=%0b exp=0", pmem_write); end
        checks++; if (pmem_address !== 32'h6000_0060) begin failures++; $display("FAIL iread_addr got=%h exp=60000060", pmem_address); end
        got = 1'b0;
        while (!got && lat < 20) begin
            wait_cycle();
            lat++;
            if (i_resp === 1'b1) got = 1'b1;
            else begin
                checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL iread_hold cycle=%0d got=%0b exp=1", lat, pmem_read); end
            end
        end
        checks++; if (!got) begin failures++; $display("FAIL iread_timeout got=no_resp exp=i_resp"); end
        checks++; if (lat != 5) begin failures++; $display("FAIL iread_latency got=%0d exp=5", lat); end
        checks++; if (i_rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
            failures++; $display("FAIL iread_line got=%h", i_rdata);
        end
        checks++; if (pmem_read !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL iread_resp_ctrl got=%0b%0b exp=00", pmem_read, d_resp); end
        i_read = 1'b0;
        wait_cycle();
        checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL iread_resp_one_cycle got=%0b exp=0", i_resp); end
    endtask

    task automatic test_dcache_write();
        int lat;
        bit got;
        logic [63:0] exp_w [4];
        exp_w[0] = 64'h0123_4567_89AB_CDEF;
        exp_w[1] = 64'hA5A5_5A5A_C3C3_3C3C;
        exp_w[2] = 64'h0F0E_0D0C_0B0A_0908;
        exp_w[3] = 64'hFEDC_BA98_7654_3210;
        d_wdata = {64'hFEDC_BA98_7654_3210, 64'h0F0E_0D0C_0B0A_0908, 64'hA5A5_5A5A_C3C3_3C3C, 64'h0123_4567_89AB_CDEF};
        wq.delete();
        d_addr  = 32'h8000_0020;
        d_write = 1'b1;
        wait_cycle();
        lat = 1;
        checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin failures++; $display("FAIL dwrite_start got=%0b%0b exp=10", pmem_write, pmem_read); end
        checks++; if (pmem_address !== 32'h8000_0020) begin failures++; $display("FAIL dwrite_addr got=%h exp=80000020", pmem_address); end
        got = 1'b0;
        while (!got && lat < 20) begin
            wait_cycle();
            lat++;
            checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL dwrite_no_iresp cycle=%0d got=%0b exp=0", lat, i_resp); end
            if (d_resp === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL dwrite_timeout got=no_resp exp=d_resp"); end
        checks++; if (lat != 5) begin failures++; $display("FAIL dwrite_latency got=%0d exp=5", lat); end
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL dwrite_beat_count got=%0d exp=4", wq.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < wq.size()) begin
                checks++; if (wq[k] !== exp_w[k]) begin failures++; $display("FAIL dwrite_beat%0d got=%h exp=%h", k, wq[k], exp_w[k]); end
            end
        end
        checks++; if (i_rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
            failures++; $display("FAIL dwrite_i_rdata_kept got=%h", i_rdata);
        end
        d_write = 1'b0;
        wait_cycle();
        checks++; if (d_resp !== 1'b0 || pmem_write !== 1'b0) begin failures++; $display("FAIL dwrite_end got=%0b%0b exp=00", d_resp, pmem_write); end
    endtask

    task automatic test_simultaneous();
        int lat;
        int dcount;
        bit got;
        logic [255:0] line_a;
        logic [255:0] line_b;
        apply_reset();
        line_a = {64'hA4A4_A4A4_A4A4_A4A4, 64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA1A1_A1A1_A1A1_A1A1};
        line_b = {64'hB4B4_B4B4_B4B4_B4B4, 64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1};
        rd_beats[0] = 64'hA1A1_A1A1_A1A1_A1A1;
        rd_beats[1] = 64'hA2A2_A2A2_A2A2_A2A2;
        rd_beats[2] = 64'hA3A3_A3A3_A3A3_A3A3;
        rd_beats[3] = 64'hA4A4_A4A4_A4A4_A4A4;
        i_addr = 32'h1000_0047;
        d_addr = 32'h2000_009F;
        i_read = 1'b1;
        d_read = 1'b1;
        wait_cycle();
        checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL sim_first_read got=%0b exp=1", pmem_read); end
        checks++; if (pmem_address !== 32'h2000_0080) begin failures++; $display("FAIL sim_first_is_d got=%h exp=20000080", pmem_address); end
        got = 1'b0;
        lat = 1;
        while (!got && lat < 20) begin
            wait_cycle();
            lat++;
            checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL sim_early_iresp cycle=%0d got=%0b exp=0", lat, i_resp); end
            if (d_resp === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL sim_d_timeout got=no_resp exp=d_resp"); end
        d_read = 1'b0;
        rd_beats[0] = 64'hB1B1_B1B1_B1B1_B1B1;
        rd_beats[1] = 64'hB2B2_B2B2_B2B2_B2B2;
        rd_beats[2] = 64'hB3B3_B3B3_B3B3_B3B3;
        rd_beats[3] = 64'hB4B4_B4B4_B4B4_B4B4;
        checks++; if (d_rdata !== line_a) begin failures++; $display("FAIL sim_d_line got=%h", d_rdata); end
        wait_cycle();
        checks++; if (pmem_read !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL sim_gap got=%0b%0b exp=00", pmem_read, d_resp); end
        wait_cycle();
        checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL sim_second_read got=%0b exp=1", pmem_read); end
        checks++; if (pmem_address !== 32'h1000_0040) begin failures++; $display("FAIL sim_second_addr got=%h exp=10000040", pmem_address); end
        got = 1'b0;
        lat = 0;
        dcount = 0;
        while (!got && lat < 20) begin
            wait_cycle();
            lat++;
            if (d_resp === 1'b1) dcount++;
            if (i_resp === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL sim_i_timeout got=no_resp exp=i_resp"); end
        checks++; if (lat != 4) begin failures++; $display("FAIL sim_i_latency got=%0d exp=4", lat); end
        checks++; if (dcount != 0) begin failures++; $display("FAIL sim_extra_dresp got=%0d exp=0", dcount); end
        checks++; if (i_rdata !== line_b) begin failures++; $display("FAIL sim_i_line got=%h", i_rdata); end
        checks++; if (d_rdata !== line_a) begin failures++; $display("FAIL sim_d_line_kept got=%h", d_rdata); end
        i_read = 1'b0;
        wait_cycle();
        checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL sim_iresp_one_cycle got=%0b exp=0", i_resp); end
    endtask

    task automatic test_fairness();
        int n;
        int cyc;
        bit who [4];
        int t [4];
        bit exp_who [4];
        exp_who[0] = 1'b1;
        exp_who[1] = 1'b0;
        exp_who[2] = 1'b1;
        exp_who[3] = 1'b0;
        n = 0;
        cyc = 0;
        i_addr = 32'h3000_0000;
        d_addr = 32'h4000_0020;
        i_read = 1'b1;
        d_read = 1'b1;
        while (n < 4 && cyc < 80) begin
            wait_cycle();
            cyc++;
            if (d_resp === 1'b1) begin
                who[n] = 1'b1; t[n] = cyc; n++;
            end else if (i_resp === 1'b1) begin
                who[n] = 1'b0; t[n] = cyc; n++;
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
        checks++; if (n != 4) begin failures++; $display("FAIL fair_count got=%0d exp=4", n); end
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                checks++; if (who[k] !== exp_who[k]) begin failures++; $display("FAIL fair_order%0d got=%s exp=%s", k, who[k] ? "D" : "I", exp_who[k] ? "D" : "I"); end
            end
        end
        for (int k = 1; k < 4; k++) begin
            if (k < n) begin
                checks++; if (t[k] - t[k-1] != 6) begin failures++; $display("FAIL fair_spacing%0d got=%0d exp=6", k, t[k] - t[k-1]); end
            end
        end
        wait_cycle();
        wait_cycle();
    endtask

    task automatic test_stall();
        int lat;
        bit got;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
        pat_len = 7;
        rd_beats[0] = 64'hC1C1_C1C1_C1C1_C1C1;
        rd_beats[1] = 64'hC2C2_C2C2_C2C2_C2C2;
        rd_beats[2] = 64'hC3C3_C3C3_C3C3_C3C3;
        rd_beats[3] = 64'hC4C4_C4C4_C4C4_C4C4;
        i_addr = 32'h7000_01E8;
        i_read = 1'b1;
        wait_cycle();
        lat = 1;
        checks++; if (pmem_address !== 32'h7000_01E0) begin failures++; $display("FAIL stall_addr got=%h exp=700001e0", pmem_address); end
        got = 1'b0;
        while (!got && lat < 30) begin
            checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL stall_hold cycle=%0d got=%0b exp=1", lat, pmem_read); end
            wait_cycle();
            lat++;
            if (i_resp === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL stall_timeout got=no_resp exp=i_resp"); end
        checks++; if (lat != 8) begin failures++; $display("FAIL stall_latency got=%0d exp=8", lat); end
        checks++; if (i_rdata !== {64'hC4C4_C4C4_C4C4_C4C4, 64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1}) begin
            failures++; $display("FAIL stall_line got=%h", i_rdata);
        end
        i_read = 1'b0;
        pat[0] = 1'b1;
        pat_len = 1;
        wait_cycle();
        checks++; if (i_resp !== 1'b0) begin failures++; $display("FAIL stall_resp_one_cycle got=%0b exp=0", i_resp); end
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        bit got;
        rd_beats[0] = 64'hE1E1_E1E1_E1E1_E1E1;
        rd_beats[1] = 64'hE2E2_E2E2_E2E2_E2E2;
        rd_beats[2] = 64'hE3E3_E3E3_E3E3_E3E3;
        rd_beats[3] = 64'hE4E4_E4E4_E4E4_E4E4;
        i_addr = 32'h5000_0010;
        i_read = 1'b1;
        wait_cycle();
        wait_cycle();
        wait_cycle();
        checks++; if (pmem_read !== 1'b1) begin failures++; $display("FAIL rstmid_in_burst got=%0b exp=1", pmem_read); end
        rst = 1'b0;
        i_read = 1'b0;
        #1;
        checks++; if (pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_pmem_read got=%0b exp=0", pmem_read); end
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin failures++; $display("FAIL rstmid_resp got=%0b%0b exp=00", i_resp, d_resp); end
        checks++; if (i_rdata !== 256'h0) begin failures++; $display("FAIL rstmid_i_rdata got=%h exp=0", i_rdata); end
        checks++; if (pmem_address !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", pmem_address); end
        wait_cycle();
        wait_cycle();
        rst = 1'b1;
        wait_cycle();
        checks++; if (i_resp !== 1'b0 || pmem_read !== 1'b0) begin failures++; $display("FAIL rstmid_after_release got=%0b%0b exp=00", i_resp, pmem_read); end
        rd_beats[0] = 64'hF1F1_F1F1_F1F1_F1F1;
        rd_beats[1] = 64'hF2F2_F2F2_F2F2_F2F2;
        rd_beats[2] = 64'hF3F3_F3F3_F3F3_F3F3;
        rd_beats[3] = 64'hF4F4_F4F4_F4F4_F4F4;
        i_addr = 32'h5000_0110;
        i_read = 1'b1;
        wait_cycle();
        lat = 1;
        checks++; if (pmem_address !== 32'h5000_0100) begin failures++; $display("FAIL rstmid_new_addr got=%h exp=50000100", pmem_address); end
        got = 1'b0;
        while (!got && lat < 20) begin
            wait_cycle();
            lat++;
            if (i_resp === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin failures++; $display("FAIL rstmid_timeout got=no_resp exp=i_resp"); end
        checks++; if (lat != 5) begin failures++; $display("FAIL rstmid_latency got=%0d exp=5", lat); end
        checks++; if (i_rdata !== {64'hF4F4_F4F4_F4F4_F4F4, 64'hF3F3_F3F3_F3F3_F3F3, 64'hF2F2_F2F2_F2F2_F2F2, 64'hF1F1_F1F1_F1F1_F1F1}) begin
            failures++; $display("FAIL rstmid_line got=%h", i_rdata);
        end
        i_read = 1'b0;
        wait_cycle();
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_simultaneous();
        test_fairness();
        test_stall();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
